// File: rtl/psk_pkg.sv
// Shared types and helpers for the BPSK/QPSK baseband mixer.
package psk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

    // Negate a w-bit two's-complement value carried sign-extended in 64 bits;
    // the most negative value clamps to the most positive instead of wrapping.
    function automatic logic signed [63:0] sat_neg(input logic signed [63:0] x, input int w);
        logic signed [63:0] lo;
        lo = -(64'sd1 <<< (w - 1));
        if (x == lo) return -lo - 64'sd1;
        return -x;
    endfunction

endpackage

// File: rtl/psk_sym_timer.sv
// Symbol-period counter: tracks the sample index inside a symbol and decides
// when the mixer may take the next symbol.
module psk_sym_timer #(
    parameter int SPS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mod_ena,
    input  logic is_load,
    input  logic is_run,
    input  logic sym_valid,
    output logic sym_ready,
    output logic boundary,
    output logic handshake
);

    localparam int CNT_W = $clog2(SPS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SPS - 1);

    logic [CNT_W-1:0] cnt;

    assign boundary  = is_run && (cnt == LAST);
    // mod_ena gates ready directly so a symbol offered as the block is
    // disabled is never consumed.
    assign sym_ready = mod_ena && (is_load || boundary);
    assign handshake = sym_ready && sym_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (!mod_ena || !is_run || handshake || boundary)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/psk_mixer.sv
// BPSK/QPSK mixer: latches symbols over valid/ready and multiplies the NCO
// carrier by symbol polarity, one registered sample per clock.
module psk_mixer
    import psk_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SPS    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mod_ena,
    input  logic                     mode,
    input  logic                     sym_valid,
    input  logic [1:0]               sym_data,
    output logic                     sym_ready,
    input  logic signed [DATA_W-1:0] sine,
    input  logic signed [DATA_W-1:0] cosine,
    output logic signed [DATA_W-1:0] i_out,
    output logic signed [DATA_W-1:0] q_out,
    output logic                     out_valid,
    output logic                     underrun
);

    state_t state, next;
    logic [1:0] sym_q;
    logic mode_q;
    logic ur_pend;
    logic boundary, handshake;
    logic signed [DATA_W-1:0] neg_sin, neg_cos, mix_i, mix_q;

    psk_sym_timer #(.SPS(SPS)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .mod_ena   (mod_ena),
        .is_load   (state == LOAD),
        .is_run    (state == RUN),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .boundary  (boundary),
        .handshake (handshake)
    );

    always_comb begin
        next = state;
        if (!mod_ena) begin
            next = IDLE;
        end else begin
            case (state)
                IDLE:    next = LOAD;
                LOAD:    if (handshake) next = RUN;
                RUN:     if (boundary && !handshake) next = LOAD;
                default: next = IDLE;
            endcase
        end
    end

    assign neg_sin = DATA_W'(sat_neg(64'(sine), DATA_W));
    assign neg_cos = DATA_W'(sat_neg(64'(cosine), DATA_W));

    always_comb begin
        mix_i = '0;
        mix_q = '0;
        if (mode_q == MODE_QPSK) begin
            mix_i = sym_q[0] ? cosine : neg_cos;
            mix_q = sym_q[1] ? sine   : neg_sin;
        end else begin
            mix_i = sym_q[0] ? sine : neg_sin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sym_q     <= '0;
            mode_q    <= MODE_BPSK;
            ur_pend   <= 1'b0;
            underrun  <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= next;
            if (handshake) begin
                sym_q  <= sym_data;
                mode_q <= mode;
            end else if (!mod_ena) begin
                sym_q  <= '0;
                mode_q <= MODE_BPSK;
            end
            // The missed boundary is reported alongside the first empty
            // output slot, one edge after the last good sample.
            ur_pend  <= mod_ena && boundary && !handshake;
            underrun <= mod_ena && ur_pend;
            if (mod_ena && state == RUN) begin
                i_out     <= mix_i;
                q_out     <= mix_q;
                out_valid <= 1'b1;
            end else begin
                i_out     <= '0;
                q_out     <= '0;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
